interboard_receiver: RTL and testbench
======================================

# interboard_receiver

Receive end of the inter-board link: accepts two-beat messages over the 4-phase Request/Ack handshake with 6-bit data, and delivers `{msg_type, number}` to the game FSM as a one-cycle strobe. Sits between the board pins (`Request_in`, `inter_data_in`, `Ack_out`) and the game controller. It is the counterpart of the link transmitter on the peer board. Decodes the RESET message type into `interboard_rst`.

## Interface
- `TIMEOUT`, 1_000_000: max cycles allowed in WAIT_B1 before the partial message is abandoned.
- `SYNC_STAGES`, 2: flip-flop stages on `Request_in` (legal values 2 or 3).

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `Request_in`  in  1  peer request; asynchronous to `clk`.
- `inter_data_in`  in  6  peer data; stable whenever `Request_in` is high.
- `Ack_out`  out  1  acknowledge to peer; registered.
- `interboard_en`  out  1  one-cycle strobe: new message valid.
- `interboard_msg_type`  out  3  message type; holds last delivered value.
- `interboard_number`  out  5  message number; holds last delivered value.
- `interboard_rst`  out  1  one-cycle strobe on a RESET (type 3'b111) message.
- `link_err`  out  1  one-cycle strobe on protocol error or timeout.

## Operation
- Beat format: bit5 is the beat tag.
  - Beat 0 = `{1'b0, msg_type[2:0], number[4:3]}`.
  - Beat 1 = `{1'b1, 2'b00, number[2:0]}`; bits [4:3] are ignored.
- `req_s` = `Request_in` after SYNC_STAGES flops. Data is sampled directly from `inter_data_in` in the cycle the FSM sees `req_s`=1.
- FSM states: SYNC, WAIT_B0, ACK_B0, WAIT_B1, ACK_B1.
  - SYNC (entered on reset): wait for `req_s`=0, then go to WAIT_B0. A request already high at reset release is never accepted.
  - WAIT_B0, `req_s`=1, tag 0: latch type and `number[4:3]`; go to ACK_B0.
  - WAIT_B0, `req_s`=1, tag 1: discard the beat and pulse `link_err`. Go to ACK_B0 with a drop flag set, so the return path is WAIT_B0 instead of WAIT_B1.
  - ACK_B0: `Ack_out`=1. On `req_s`=0, go to WAIT_B1 (or to WAIT_B0 if the drop flag is set); `Ack_out` falls on that same transition.
  - WAIT_B1, `req_s`=1, tag 1: form the message and go to ACK_B1.
    - Type != 3'b111: `interboard_msg_type`/`interboard_number` update and `interboard_en` pulses.
    - Type == 3'b111: `interboard_rst` pulses. `interboard_en` does not pulse and the output registers do not change.
  - WAIT_B1, `req_s`=1, tag 0: pulse `link_err` and treat the beat as a new beat 0 (relatch, go to ACK_B0).
  - WAIT_B1 timeout: the counter reaches TIMEOUT-1 with `req_s`=0 → pulse `link_err`, discard the partial message, go to WAIT_B0.
  - ACK_B1: `Ack_out`=1. On `req_s`=0, go to WAIT_B0.
- Timeout counter:
  - Cleared on every entry to WAIT_B1; counts only in WAIT_B1.
  - Width is clog2(TIMEOUT); it saturates and never wraps.
- A request that stays high forever holds the FSM in ACK_* indefinitely. This is not an error.
- `Ack_out` is high exactly in ACK_B0 and ACK_B1.

## Timing
- Reset values: `Ack_out`=0, `interboard_en`=0, `interboard_msg_type`=0, `interboard_number`=0, `interboard_rst`=0, `link_err`=0, FSM=SYNC, sync flops=0, counter=0.
- Rising edge of `Request_in` → FSM sees `req_s` after SYNC_STAGES edges; `Ack_out` rises on the next edge (3 cycles with the default).
- Falling edge of `Request_in` → `Ack_out` falls SYNC_STAGES+1 cycles later.
- Beat 1 `Request_in` rise → `interboard_en`/`interboard_rst` high for exactly one cycle, in the same cycle `Ack_out` first goes high.
- Outputs are registered; there is no combinational path from any input to any output.
- `rst` asserted mid-message: all state clears immediately, `Ack_out` drops asynchronously, and the partial message is lost.

## Test plan
- Normal message: type 3'b010, number 5'd19. Beats 0x0A, 0x23 → one `interboard_en` pulse; type=2, number=19; `Ack_out` rises 3 cycles after each Request rise.
- RESET message: type 3'b111, number 0 → `interboard_rst` pulses once; `interboard_en` stays 0; previous type/number are held.
- Out-of-order: a lone beat 1 (0x25) in WAIT_B0 → Ack handshake completes, `link_err` pulses, no `en`. A following valid 0x0A/0x23 pair delivers type 2, number 19.
- Timeout with TIMEOUT=16: beat 0 only, then idle 16 cycles → `link_err` at cycle 16 of WAIT_B1. A late beat 1 is then dropped with a second `link_err`.
- Reset with `Request_in` held high: release `rst` → `Ack_out` stays 0 until Request falls. The next full handshake is accepted normally.
- Async reset during ACK_B1 (`Ack_out`=1) → `Ack_out` goes 0 within the same cycle and all outputs return to their reset values.

Source files
------------

// File: rtl/interboard_receiver.sv
// Receive side of the inter-board link: 4-phase Request/Ack handshake, two 6-bit beats
// per message, delivered to the game FSM as a one-cycle strobe with held type/number.
module interboard_receiver #(
  parameter int TIMEOUT     = 1_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       link_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] TYPE_RESET = 3'b111;

  typedef enum logic [2:0] {SYNC, WAIT_B0, ACK_B0, WAIT_B1, ACK_B1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic [SYNC_STAGES-1:0] fill_p0;
  logic                   req_s;
  logic                   tag;
  logic                   drop, drop_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   timed_out;
  logic [2:0]             type_l;
  logic [1:0]             num_hi;
  logic                   latch_b0, deliver, deliver_rst, err;

  // Request synchronizer; fill_p0 marks when the chain holds only post-reset samples,
  // so a request already high at reset release cannot slip through as a fresh low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      fill_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], Request_in};
      fill_p0 <= {fill_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign req_s     = sync_p0[SYNC_STAGES-1];
  assign tag       = inter_data_in[5];
  assign timed_out = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (fill_p0[SYNC_STAGES-1] && !req_s) state_nxt = WAIT_B0;
      WAIT_B0: if (req_s) state_nxt = ACK_B0;
      ACK_B0:  if (!req_s) state_nxt = drop ? WAIT_B0 : WAIT_B1;
      WAIT_B1: begin
        if (req_s)          state_nxt = tag ? ACK_B1 : ACK_B0;
        else if (timed_out) state_nxt = WAIT_B0;
      end
      ACK_B1:  if (!req_s) state_nxt = WAIT_B0;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    latch_b0    = 1'b0;
    deliver     = 1'b0;
    deliver_rst = 1'b0;
    err         = 1'b0;
    drop_nxt    = drop;
    if (state == WAIT_B0 && req_s) begin
      latch_b0 = !tag;
      err      = tag;
      drop_nxt = tag;
    end
    if (state == WAIT_B1) begin
      if (req_s && tag) begin
        deliver     = (type_l != TYPE_RESET);
        deliver_rst = (type_l == TYPE_RESET);
      end else if (req_s) begin
        latch_b0 = 1'b1;
        err      = 1'b1;
        drop_nxt = 1'b0;
      end else begin
        err = timed_out;
      end
    end
  end

  // Registered outputs and control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop                <= 1'b0;
      cnt                 <= '0;
      Ack_out             <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_rst      <= 1'b0;
      link_err            <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
    end else begin
      drop           <= drop_nxt;
      Ack_out        <= (state_nxt == ACK_B0) || (state_nxt == ACK_B1);
      interboard_en  <= deliver;
      interboard_rst <= deliver_rst;
      link_err       <= err;
      if (state != WAIT_B1)  cnt <= '0;
      else if (!timed_out)   cnt <= cnt + 1'b1;
      if (deliver) begin
        interboard_msg_type <= type_l;
        interboard_number   <= {num_hi, inter_data_in[2:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_b0) begin
      type_l <= inter_data_in[4:2];
      num_hi <= inter_data_in[1:0];
    end
  end

endmodule

// File: tb/tb_interboard_receiver.sv
// Directed bench for interboard_receiver: message-level reference model checked every
// cycle, plus literal expectations for latency, delivered values and strobe counts.
module tb_interboard_receiver;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Request_in = 1'b0;
  logic [5:0] inter_data_in = 6'd0;
  logic       Ack_out, interboard_en, interboard_rst, link_err;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;

  int total = 0;
  int bad   = 0;

  interboard_receiver #(.TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .link_err            (link_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the link sees Request two edges late; it is either holding off
  // after reset, ready for a beat, or acknowledging one. A beat-0 leaves a partial message.
  localparam int HOLD = 0, READY = 1, ACKING = 2;
  int         m_mode, m_age, m_idle;
  logic       m_r1, m_r2, m_partial;
  logic [2:0] m_type;
  logic [1:0] m_hi;
  logic       exp_ack = 1'b0, exp_en = 1'b0, exp_rstp = 1'b0, exp_err = 1'b0;
  logic [2:0] exp_type = 3'd0;
  logic [4:0] exp_num = 5'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r1 <= 1'b0; m_r2 <= 1'b0; m_age <= 0; m_mode <= HOLD;
      m_partial <= 1'b0; m_idle <= 0;
      exp_ack <= 1'b0; exp_en <= 1'b0; exp_rstp <= 1'b0; exp_err <= 1'b0;
      exp_type <= 3'd0; exp_num <= 5'd0;
    end else begin
      m_r1 <= Request_in;
      m_r2 <= m_r1;
      if (m_age < 2) m_age <= m_age + 1;
      exp_en <= 1'b0; exp_rstp <= 1'b0; exp_err <= 1'b0;
      case (m_mode)
        HOLD: if (m_age >= 2 && !m_r2) m_mode <= READY;
        ACKING: if (!m_r2) begin
          exp_ack <= 1'b0; m_mode <= READY; m_idle <= 0;
        end
        default: begin
          if (m_r2) begin
            exp_ack <= 1'b1; m_mode <= ACKING;
            if (!inter_data_in[5]) begin
              exp_err   <= m_partial;
              m_partial <= 1'b1;
              m_type    <= inter_data_in[4:2];
              m_hi      <= inter_data_in[1:0];
            end else if (m_partial) begin
              m_partial <= 1'b0;
              if (m_type == 3'b111) exp_rstp <= 1'b1;
              else begin
                exp_en   <= 1'b1;
                exp_type <= m_type;
                exp_num  <= {m_hi, inter_data_in[2:0]};
              end
            end else begin
              exp_err <= 1'b1;
            end
          end else if (m_partial) begin
            if (m_idle + 1 == TMO) begin
              exp_err   <= 1'b1;
              m_partial <= 1'b0;
            end
            m_idle <= m_idle + 1;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("ack",    int'(Ack_out),             int'(exp_ack));
    chk("en",     int'(interboard_en),       int'(exp_en));
    chk("rstp",   int'(interboard_rst),      int'(exp_rstp));
    chk("err",    int'(link_err),            int'(exp_err));
    chk("type",   int'(interboard_msg_type), int'(exp_type));
    chk("number", int'(interboard_number),   int'(exp_num));
  end

  int en_cnt = 0, rstp_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    en_cnt   <= en_cnt + int'(interboard_en);
    rstp_cnt <= rstp_cnt + int'(interboard_rst);
    err_cnt  <= err_cnt + int'(link_err);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [5:0] d);
    int n;
    @(negedge clk);
    inter_data_in = d;
    Request_in    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    if (!Ack_out) chk("ack_rise_bound", 0, 1);
    else          chk("ack_rise_latency", n, 3);
    @(negedge clk);
    Request_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (Ack_out && n < 20);
    if (Ack_out) chk("ack_fall_bound", 0, 1);
    else         chk("ack_fall_latency", n, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int e0, r0, x0, n;
    #1 rst = 1'b1;
    idle(3);
    chk("rst_ack", int'(Ack_out), 0);
    chk("rst_type", int'(interboard_msg_type), 0);
    chk("rst_number", int'(interboard_number), 0);
    rst = 1'b0;
    idle(4);

    // Normal message: type 2, number 19
    e0 = en_cnt;
    send_beat(6'h0A);
    send_beat(6'h23);
    idle(3);
    chk("normal_en_count", en_cnt - e0, 1);
    chk("normal_type", int'(interboard_msg_type), 2);
    chk("normal_number", int'(interboard_number), 19);

    // RESET message: strobe only, held outputs unchanged
    e0 = en_cnt; r0 = rstp_cnt;
    send_beat(6'h1C);
    send_beat(6'h20);
    idle(3);
    chk("reset_msg_rstp", rstp_cnt - r0, 1);
    chk("reset_msg_en", en_cnt - e0, 0);
    chk("reset_msg_type_held", int'(interboard_msg_type), 2);
    chk("reset_msg_number_held", int'(interboard_number), 19);

    // Lone beat 1, then a type 5 / number 6 message with beat-1 bits [4:3] set
    e0 = en_cnt; x0 = err_cnt;
    send_beat(6'h25);
    idle(2);
    chk("lone_b1_err", err_cnt - x0, 1);
    chk("lone_b1_en", en_cnt - e0, 0);
    send_beat(6'h14);
    send_beat(6'h3E);
    idle(3);
    chk("after_lone_en", en_cnt - e0, 1);
    chk("after_lone_type", int'(interboard_msg_type), 5);
    chk("after_lone_number", int'(interboard_number), 6);

    // Timeout in WAIT_B1, then a late beat 1 is dropped
    e0 = en_cnt; x0 = err_cnt;
    send_beat(6'h0A);
    n = 0;
    do begin @(negedge clk); n++; end while (!link_err && n < 40);
    chk("timeout_cycles", n, 16);
    send_beat(6'h23);
    idle(3);
    chk("timeout_err_count", err_cnt - x0, 2);
    chk("timeout_en", en_cnt - e0, 0);
    chk("timeout_type_held", int'(interboard_msg_type), 5);

    // Two beat 0s in a row: second replaces the first
    e0 = en_cnt; x0 = err_cnt;
    send_beat(6'h0A);
    send_beat(6'h14);
    send_beat(6'h21);
    idle(3);
    chk("double_b0_err", err_cnt - x0, 1);
    chk("double_b0_en", en_cnt - e0, 1);
    chk("double_b0_type", int'(interboard_msg_type), 5);
    chk("double_b0_number", int'(interboard_number), 1);

    // Reset released with Request held high
    @(negedge clk);
    inter_data_in = 6'h0A;
    Request_in    = 1'b1;
    #2 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(10);
    chk("held_req_no_ack", int'(Ack_out), 0);
    Request_in = 1'b0;
    idle(5);
    e0 = en_cnt;
    send_beat(6'h0A);
    send_beat(6'h23);
    idle(3);
    chk("post_reset_en", en_cnt - e0, 1);
    chk("post_reset_type", int'(interboard_msg_type), 2);
    chk("post_reset_number", int'(interboard_number), 19);

    // Asynchronous reset while in ACK_B1
    send_beat(6'h14);
    @(negedge clk);
    inter_data_in = 6'h26;
    Request_in    = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!Ack_out && n < 20);
    chk("ackb1_reached", int'(Ack_out), 1);
    chk("ackb1_type", int'(interboard_msg_type), 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ack", int'(Ack_out), 0);
    chk("async_rst_type", int'(interboard_msg_type), 0);
    chk("async_rst_number", int'(interboard_number), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("async_rst_held_req", int'(Ack_out), 0);
    Request_in = 1'b0;
    idle(5);
    e0 = en_cnt;
    send_beat(6'h0A);
    send_beat(6'h23);
    idle(3);
    chk("recover_en", en_cnt - e0, 1);
    chk("recover_number", int'(interboard_number), 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
